id_ex_elastic_buf: RTL and testbench

//  Parametrised elastic successor to the ID->EX pipeline register. It is a DEPTH-entry

---
 rtl/id_ex_elastic_buf.sv | 95 +++++++++
 tb/tb_id_ex_elastic_buf.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_elastic_buf.sv
// ID->EX elastic stage: DEPTH-entry first-word-fall-through buffer with a
// QED-valid sideband and a hold-flag-driven flush that empties the stage.
module id_ex_elastic_buf #(
  parameter int unsigned            DATA_W      = 331,
  parameter int unsigned            DEPTH       = 2,
  parameter int unsigned            HOLD_W      = 3,
  parameter logic [HOLD_W-1:0]      FLUSH_LEVEL = HOLD_W'(3),
  parameter logic [DATA_W-1:0]      NOP_VALUE   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HOLD_W-1:0]         hold_flag_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         in_data_i,
  input  logic                      in_qed_vld_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic                      out_qed_vld_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  qed_q, qed_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              flush_c;
  logic              push_c;
  logic              pop_c;

  // Handshakes, head presentation and next-state for pointers/count/qed.
  always_comb begin
    flush_c       = (hold_flag_i >= FLUSH_LEVEL);
    in_ready_o    = (count_q < CNT_W'(DEPTH)) & ~flush_c;
    out_valid_o   = (count_q != '0) & ~flush_c;
    push_c        = in_valid_i & in_ready_o;
    pop_c         = out_valid_o & out_ready_i;
    out_data_o    = out_valid_o ? mem_q[rd_ptr_q] : NOP_VALUE;
    out_qed_vld_o = out_valid_o & qed_q[rd_ptr_q];
    count_o       = count_q;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    qed_d    = qed_q;

    if (flush_c) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      qed_d    = '0;
    end else begin
      if (push_c) begin
        qed_d[wr_ptr_q] = in_qed_vld_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers, occupancy and qed sideband.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      qed_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      qed_q    <= qed_d;
    end
  end

  // Payload storage; not reset, only written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_buf.sv
// Bench for id_ex_elastic_buf: directed scenarios plus random traffic,
// all checked against a queue-based model of the buffer.
module tb_id_ex_elastic_buf;

  localparam int unsigned DATA_W = 331;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned HOLD_W = 3;

  typedef struct packed {
    logic              q;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk;
  logic              rst;
  logic [HOLD_W-1:0] hold_flag;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_qed;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_qed;
  logic [1:0]        count;

  int   n_tot;
  int   n_bad;
  ent_t mq[$];
  logic acc;

  id_ex_elastic_buf dut (
    .clk          (clk),
    .rst          (rst),
    .hold_flag_i  (hold_flag),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_qed_vld_i (in_qed),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_qed_vld_o(out_qed),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [351:0] t;
    for (int k = 0; k < 11; k++) t[k*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic [HOLD_W-1:0] hold, input logic vld, input logic [DATA_W-1:0] d,
                      input logic qv, input logic ordy, output logic accepted);
    logic fl, e_ir, e_ov;
    ent_t h;
    @(negedge clk);
    hold_flag = hold; in_valid = vld; in_data = d; in_qed = qv; out_ready = ordy;
    #1;
    fl   = (hold >= 3'd3);
    e_ir = (mq.size() < DEPTH) && !fl;
    e_ov = (mq.size() != 0) && !fl;
    h    = '0;
    if (e_ov) h = mq[0];
    chk("in_ready",  DATA_W'(in_ready),  DATA_W'(e_ir));
    chk("out_valid", DATA_W'(out_valid), DATA_W'(e_ov));
    chk("out_data",  out_data,           e_ov ? h.d : '0);
    chk("out_qed",   DATA_W'(out_qed),   DATA_W'(e_ov & h.q));
    chk("count",     DATA_W'(count),     DATA_W'(mq.size()));
    accepted = vld & e_ir;
    if (fl) mq.delete();
    else begin
      if (e_ov && ordy) void'(mq.pop_front());
      if (accepted) mq.push_back(ent_t'{q: qv, d: d});
    end
  endtask

  // Offer one word until it is accepted, with a cycle bound.
  task automatic offer(input logic [DATA_W-1:0] d, input logic qv, input logic ordy);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(3'd0, 1'b1, d, qv, ordy, a);
    if (!a) begin
      n_tot++; n_bad++;
      $display("FAIL offer_timeout: got not-accepted want accepted");
    end
  endtask

  initial begin
    logic [DATA_W-1:0] a_w, b_w, c_w;
    n_tot = 0; n_bad = 0;
    rst = 1'b0; hold_flag = '0; in_valid = 1'b0; in_data = '0; in_qed = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset release, idle.
    step(3'd0, 1'b0, '0, 1'b0, 1'b0, acc);

    // Single push with qed, consumed immediately.
    a_w = rnd_data(); a_w[7:0] = 8'h13;
    step(3'd0, 1'b1, a_w, 1'b1, 1'b1, acc);
    step(3'd0, 1'b0, '0, 1'b0, 1'b1, acc);
    step(3'd0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Backpressure: A, B fill the buffer, C waits, then drains in order.
    a_w = rnd_data(); b_w = rnd_data(); c_w = rnd_data();
    offer(a_w, 1'b0, 1'b0);
    offer(b_w, 1'b1, 1'b0);
    step(3'd0, 1'b1, c_w, 1'b0, 1'b0, acc);
    step(3'd0, 1'b1, c_w, 1'b0, 1'b0, acc);
    offer(c_w, 1'b0, 1'b1);
    repeat (3) step(3'd0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Sustained push+pop, words 0..7.
    for (int i = 0; i < 8; i++) step(3'd0, 1'b1, DATA_W'(i), i[0], 1'b1, acc);
    repeat (2) step(3'd0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Flush with a full buffer and a word offered.
    offer(rnd_data(), 1'b1, 1'b0);
    offer(rnd_data(), 1'b1, 1'b0);
    step(3'd3, 1'b1, rnd_data(), 1'b1, 1'b1, acc);
    step(3'd0, 1'b0, '0, 1'b0, 1'b0, acc);
    // Flush held several cycles, then first push on release.
    repeat (3) step(3'd5, 1'b1, rnd_data(), 1'b1, 1'b1, acc);
    step(3'd0, 1'b1, rnd_data(), 1'b1, 1'b0, acc);
    step(3'd2, 1'b0, '0, 1'b0, 1'b0, acc);

    // Async reset between edges with one entry held.
    @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_qed",   DATA_W'(out_qed),   '0);
    chk("rst_count",     DATA_W'(count),     '0);
    chk("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1));
    chk("rst_out_data",  out_data,           '0);
    mq.delete();
    @(negedge clk); rst = 1'b1;

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [HOLD_W-1:0] h;
      h = ($urandom_range(0, 11) == 0) ? HOLD_W'($urandom_range(3, 7)) : HOLD_W'($urandom_range(0, 2));
      step(h, 1'($urandom), rnd_data(), 1'($urandom), 1'($urandom), acc);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
